// File: rtl/gnw_audio_shaper.sv
// 1-bit speaker drive to 14-bit PCM: windowed density, optional one-pole low-pass, volume shift.
// Define GNW_AUDIO_IIR_EN to include the low-pass filter; otherwise each window's density is output directly.
module gnw_audio_shaper #(
  parameter int WINDOW_LOG2 = 11,
  parameter int IIR_SHIFT   = 2
) (
  input  logic        clk_sys_99_287,
  input  logic        RESET,
  input  logic        sound,
  input  logic [1:0]  volume,
  output logic [15:0] audio_out,
  output logic        sample_strobe
);

  localparam int W = WINDOW_LOG2;

  if (WINDOW_LOG2 < 8 || WINDOW_LOG2 > 14) begin : g_bad_window
    $error("gnw_audio_shaper: WINDOW_LOG2 must be 8..14");
  end
  if (IIR_SHIFT < 1 || IIR_SHIFT > 4) begin : g_bad_shift
    $error("gnw_audio_shaper: IIR_SHIFT must be 1..4");
  end

  logic [W-1:0]   win_cnt;
  logic [W:0]     ones;
  logic [W:0]     ones_next;
  logic [W-1:0]   clamped;
  logic [2*W-1:0] dup;
  logic [13:0]    raw;
  logic [13:0]    raw_next;
  logic           raw_valid;
  logic [13:0]    y_new;
  logic [13:0]    scaled;

  // The closing slot's own sound bit is folded in before clamping, so every slot counts.
  // Replicating the MSBs into the low bits maps full scale to exactly 16383.
  always_comb begin
    ones_next = ones + {{W{1'b0}}, sound};
    clamped   = ones_next[W] ? {W{1'b1}} : ones_next[W-1:0];
    dup       = {clamped, clamped};
    raw_next  = dup[2*W-1 -: 14];
  end

`ifdef GNW_AUDIO_IIR_EN
  logic [13:0]        y;
  logic signed [14:0] diff;
  logic signed [14:0] step;
  logic signed [14:0] sum;

  // Arithmetic shift floors toward -inf, so y never overshoots raw and cannot wrap.
  always_comb begin
    diff  = $signed({1'b0, raw}) - $signed({1'b0, y});
    step  = diff >>> IIR_SHIFT;
    sum   = $signed({1'b0, y}) + step;
    y_new = sum[13:0];
  end

  always_ff @(posedge clk_sys_99_287) begin
    if (RESET) begin
      y <= '0;
    end else if (raw_valid) begin
      y <= y_new;
    end
  end
`else
  always_comb begin
    y_new = raw;
  end
`endif

  always_comb begin
    case (volume)
      2'd0:    scaled = '0;
      2'd1:    scaled = y_new >> 2;
      2'd2:    scaled = y_new >> 1;
      default: scaled = y_new;
    endcase
  end

  // Window close loads raw and restarts the ones count in the same edge.
  always_ff @(posedge clk_sys_99_287) begin
    if (RESET) begin
      win_cnt       <= '0;
      ones          <= '0;
      raw           <= '0;
      raw_valid     <= 1'b0;
      audio_out     <= '0;
      sample_strobe <= 1'b0;
    end else begin
      win_cnt       <= win_cnt + 1'b1;
      sample_strobe <= raw_valid;
      if (win_cnt == {W{1'b1}}) begin
        raw       <= raw_next;
        ones      <= '0;
        raw_valid <= 1'b1;
      end else begin
        ones      <= ones_next;
        raw_valid <= 1'b0;
      end
      if (raw_valid) begin
        audio_out <= {2'b00, scaled};
      end
    end
  end

endmodule
